clock_divider_by_4: RTL and testbench

CLOCK_DIVIDER_BY_4 -- requirements
Module: clock_divider_by_4

---
 rtl/clock_divider_by_4.sv | 43 ++++
 tb/tb_clock_divider_by_4.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_by_4.sv
// Divide-by-4 clock generator: a free-running 2-bit phase counter with
// glitch-free registered clock outputs and a last-phase strobe.
module clock_divider_by_4 #(
    parameter logic [1:0] INIT_PHASE = 2'd0
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic       clk_out,
    output logic       clk_out_n,
    output logic [1:0] phase,
    output logic       tick
);

    logic [1:0] phase_q;
    logic [1:0] phase_next;
    logic       clk_out_q;
    logic       clk_out_n_q;
    logic       tick_q;

    assign phase_next = phase_q + 2'd1;

    // Every output is its own flop, loaded from the next phase, so none of
    // them has logic after the register and all change on the same edge.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            phase_q     <= INIT_PHASE;
            clk_out_q   <= INIT_PHASE[1];
            clk_out_n_q <= ~INIT_PHASE[1];
            tick_q      <= (INIT_PHASE == 2'd3);
        end else begin
            phase_q     <= phase_next;
            clk_out_q   <= phase_next[1];
            clk_out_n_q <= ~phase_next[1];
            tick_q      <= (phase_next == 2'd3);
        end
    end

    assign phase     = phase_q;
    assign clk_out   = clk_out_q;
    assign clk_out_n = clk_out_n_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_clock_divider_by_4.sv
// Directed bench for clock_divider_by_4: default-phase and INIT_PHASE=2 instances.
module tb_clock_divider_by_4;

    logic       clk_in;
    logic       reset0;
    logic       reset2;
    logic       clk_out0, clk_out_n0, tick0;
    logic [1:0] phase0;
    logic       clk_out2, clk_out_n2, tick2;
    logic [1:0] phase2;

    int total;
    int bad;
    logic [1:0] exp_phase;
    logic [4:0] exp_vec;
    logic [4:0] got_vec;

    clock_divider_by_4 dut0 (
        .clk_in    (clk_in),
        .reset     (reset0),
        .clk_out   (clk_out0),
        .clk_out_n (clk_out_n0),
        .phase     (phase0),
        .tick      (tick0)
    );

    clock_divider_by_4 #(.INIT_PHASE(2'd2)) dut2 (
        .clk_in    (clk_in),
        .reset     (reset2),
        .clk_out   (clk_out2),
        .clk_out_n (clk_out_n2),
        .phase     (phase2),
        .tick      (tick2)
    );

    // Rising edges at 5, 15, 25 ns ...
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Vector layout: {phase, clk_out, clk_out_n, tick}, derived only from exp_phase.
    function automatic logic [4:0] model_vec(input logic [1:0] p);
        return {p, p[1], ~p[1], (p == 2'd3)};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            #6;
            got_vec = {phase0, clk_out0, clk_out_n0, tick0};
            total++;
            if (got_vec !== 5'b00_0_1_0) begin
                bad++;
                $display("FAIL reset_hold t=%0t got=%b want=%b", $time, got_vec, 5'b00010);
            end
        end
        #2;
        reset0 = 1'b1;
        exp_phase = 2'd0;
    endtask

    task automatic test_free_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_in);
            #1;
            exp_phase = exp_phase + 2'd1;
            exp_vec = model_vec(exp_phase);
            got_vec = {phase0, clk_out0, clk_out_n0, tick0};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL free_run_rise t=%0t got=%b want=%b", $time, got_vec, exp_vec);
            end
            // Just past the falling edge nothing may have moved.
            #5;
            got_vec = {phase0, clk_out0, clk_out_n0, tick0};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL free_run_fall t=%0t got=%b want=%b", $time, got_vec, exp_vec);
            end
        end
    endtask

    task automatic advance_to(input logic [1:0] target);
        for (int i = 0; i < 4 && exp_phase != target; i++) begin
            @(posedge clk_in);
            #1;
            exp_phase = exp_phase + 2'd1;
        end
    endtask

    task automatic test_async_reset();
        // Abort while clk_out is low and phase is 1.
        advance_to(2'd1);
        #2;
        reset0 = 1'b0;
        #1;
        total++;
        if (phase0 !== 2'd0) begin
            bad++;
            $display("FAIL async_reset_phase got=%0d want=0", phase0);
        end
        // Held through clock activity.
        repeat (2) @(posedge clk_in);
        #1;
        got_vec = {phase0, clk_out0, clk_out_n0, tick0};
        total++;
        if (got_vec !== 5'b00_0_1_0) begin
            bad++;
            $display("FAIL reset_held_clocking got=%b want=%b", got_vec, 5'b00010);
        end
        @(negedge clk_in);
        reset0 = 1'b1;
        exp_phase = 2'd0;
        // Abort while clk_out is high.
        advance_to(2'd2);
        total++;
        if (clk_out0 !== 1'b1) begin
            bad++;
            $display("FAIL pre_abort_clk_out got=%b want=1", clk_out0);
        end
        #2;
        reset0 = 1'b0;
        #1;
        total++;
        if ({clk_out0, clk_out_n0} !== 2'b01) begin
            bad++;
            $display("FAIL async_reset_clk_out got=%b want=01", {clk_out0, clk_out_n0});
        end
        @(negedge clk_in);
        reset0 = 1'b1;
        exp_phase = 2'd0;
        // Restart: low after first edge, rises on the second.
        test_free_run(4);
    endtask

    task automatic test_init_phase2();
        @(posedge clk_in);
        #1;
        got_vec = {phase2, clk_out2, clk_out_n2, tick2};
        total++;
        if (got_vec !== 5'b10_1_0_0) begin
            bad++;
            $display("FAIL init2_reset got=%b want=%b", got_vec, 5'b10100);
        end
        @(negedge clk_in);
        reset2 = 1'b1;
        @(posedge clk_in);
        #1;
        got_vec = {phase2, clk_out2, clk_out_n2, tick2};
        total++;
        if (got_vec !== 5'b11_1_0_1) begin
            bad++;
            $display("FAIL init2_edge1 got=%b want=%b", got_vec, 5'b11101);
        end
        @(posedge clk_in);
        #1;
        got_vec = {phase2, clk_out2, clk_out_n2, tick2};
        total++;
        if (got_vec !== 5'b00_0_1_0) begin
            bad++;
            $display("FAIL init2_edge2 got=%b want=%b", got_vec, 5'b00010);
        end
        @(posedge clk_in);
        #1;
        got_vec = {phase2, clk_out2, clk_out_n2, tick2};
        total++;
        if (got_vec !== 5'b01_0_1_0) begin
            bad++;
            $display("FAIL init2_edge3 got=%b want=%b", got_vec, 5'b01010);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_phase = 2'd0;
        reset0 = 1'b0;
        reset2 = 1'b0;
        test_reset();
        test_free_run(20);
        test_async_reset();
        test_init_phase2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
